model_table_reader: RTL and testbench
=====================================

// Module: model_table_reader
// PURPOSE
//  Read-side initiator for the model_config_mem read port (model_addr/model_read_valid/model_data).
//  On a start pulse it walks the FORWARD_COMPUTE or BACKWARD_COMPUTE table plus INTERMEDIATE_MEM, layer by layer.
//  It emits one layer descriptor per layer on a valid/ready stream to the training scheduler.
//  Forward walks layer 0..N-1; backward walks N-1..0.
// PARAMETERS
//  READ_LAT     1   cycles from model_read_valid_o high to model_data_i valid (>=1)
//  MAX_LAYERS   32  table depth; index field is addr[4:0]
// PORTS
//  clk_i               in   1   clock, all logic on rising edge
//  rst_ni              in   1   asynchronous active-low reset
//  start_i             in   1   one-cycle start request; sampled only in IDLE
//  direction_i         in   1   0 = forward walk, 1 = backward walk; sampled with start_i
//  num_layers_i        in   6   layer count N (FORWARD_LENGTH/BACKWARD_LENGTH value); >32 clamps to 32
//  model_addr_o        out  32  read address: [10:8] table select, [4:0] layer index, other bits 0
//  model_read_valid_o  out  1   one-cycle read strobe
//  model_data_i        in   32  read data, valid READ_LAT cycles after strobe
//  desc_valid_o        out  1   descriptor valid
//  desc_ready_i        in   1   consumer ready
//  desc_layer_o        out  5   layer index of descriptor
//  desc_compute_o      out  32  compute-table entry for layer
//  desc_interm_o       out  32  intermediate-mem entry for layer
//  busy_o              out  1   high from accepted start until done_o
//  done_o              out  1   one-cycle pulse after last descriptor handshake (or empty walk)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-walk aborts immediately; no done_o.
//  FSM: IDLE -> RD_C -> WT_C -> RD_I -> WT_I -> EMIT -> (next layer: RD_C | last: DONE) -> IDLE.
//   IDLE: start_i=1 latches direction and clamped N. N=0 goes straight to DONE with no reads.
//     Otherwise go to RD_C with idx = 0 (fwd) or N-1 (bwd).
//   RD_C: model_read_valid_o=1 for exactly one cycle, addr = {FWD|BWD_COMPUTE,idx}.
//   WT_C: wait READ_LAT cycles total, counted from the strobe. Capture model_data_i into desc_compute_o.
//   RD_I/WT_I: same sequence with addr = {INTERMEDIATE_MEM,idx}, captured into desc_interm_o.
//   EMIT: desc_valid_o=1. desc_* stay stable until desc_ready_i=1.
//     On handshake, idx steps +1 (fwd) or -1 (bwd). The last layer is idx==N-1 (fwd) or idx==0 (bwd).
//   DONE: done_o=1 one cycle, busy_o drops the same cycle; return to IDLE.
//  model_addr_o holds the last address between strobes. Only one read is ever outstanding.
//  Throughput with ready held high: 2*(READ_LAT+1)+1 cycles per layer.
//  start_i while busy is ignored; it is not queued.
//  desc_valid_o goes high the cycle after the WT_I capture. Combinational ready->valid paths are forbidden.
//  Index arithmetic is 5-bit. Backward decrement from 0 never occurs because of the last-layer check.
//  busy_o=1 from the cycle after start acceptance.
// STRUCTURE
//  Table-select codes come from rtl/include/define.v; no local redefinition:
//   `INTERMEDIATE_MEM, `FORWARD_COMPUTE, `BACKWARD_COMPUTE.
//  FSM state encodings are localparams in this file.
//  One sub-module, model_read_port: issues the strobe, counts READ_LAT, returns rdata + rvalid pulse.
//   The FSM uses it for both table reads.
// TESTING (bench: behavioural memory with READ_LAT=1)
//  Memory preload: compute_fwd[i]=100+i, compute_bwd[i]=300+i, interm[i]=200+i.
//  1 Fwd, N=4, ready=1 -> 4 descriptors: (0,100,200)(1,101,201)(2,102,202)(3,103,203).
//     done_o one cycle later; 8 read strobes total.
//  2 Bwd, N=3, ready=1 -> descriptors (2,302,202)(1,301,201)(0,300,200).
//     Addresses use [10:8]=`BACKWARD_COMPUTE / `INTERMEDIATE_MEM.
//  3 Fwd N=2, ready low 5 cycles on first descriptor -> desc_* stable and no new strobes while stalled.
//     Second descriptor follows the handshake.
//  4 N=0 -> no strobes; done_o pulses 1 cycle after start. N=40 -> exactly 32 descriptors.
//  5 Start asserted again mid-walk -> ignored, sequence unchanged.
//     rst_ni low mid-WT_I -> outputs 0 immediately and no done_o; next start runs cleanly.

Source files
------------

// File: rtl/model_table_reader_pkg.sv
// model_table_reader_pkg
//   Shared constants and helpers for the model table reader:
//   table-select codes (taken from define.v), field widths, address packing
//   and layer-count clamping.
`include "define.v"

package model_table_reader_pkg;

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned LAYER_W = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [2:0] SEL_FWD = `FORWARD_COMPUTE;
  localparam logic [2:0] SEL_BWD = `BACKWARD_COMPUTE;
  localparam logic [2:0] SEL_INT = `INTERMEDIATE_MEM;

  // Read address: [10:8] table select, [4:0] layer index, all other bits zero.
  function automatic logic [ADDR_W-1:0] table_addr(input logic [2:0]       sel,
                                                   input logic [IDX_W-1:0] idx);
    logic [ADDR_W-1:0] a;
    a       = '0;
    a[10:8] = sel;
    a[4:0]  = idx;
    return a;
  endfunction

  // Layer counts above the table depth are clamped to the table depth.
  function automatic logic [LAYER_W-1:0] clamp_layers(input logic [LAYER_W-1:0] n,
                                                      input logic [LAYER_W-1:0] max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/include/define.v
// Table-select codes shared by the model_config_mem read port and its initiators.
// They occupy address bits [10:8] of a model_config_mem read address.
`ifndef MODEL_CONFIG_DEFINE_V
`define MODEL_CONFIG_DEFINE_V
`define FORWARD_COMPUTE   3'd1
`define BACKWARD_COMPUTE  3'd2
`define INTERMEDIATE_MEM  3'd3
`endif

// File: rtl/model_table_reader_read_port.sv
// model_read_port
//   Issues a single read strobe toward model_config_mem and returns the read
//   data READ_LAT cycles later together with a one-cycle rvalid pulse.
//   Only one read may be outstanding; the requester waits for rvalid.
// Ports
//   clk_i, rst_ni        clock / async active-low reset
//   req_i                one-cycle read request; strobe goes out the same cycle
//   addr_i               read address presented with req_i
//   model_addr_o         address to memory; holds the last address between strobes
//   model_read_valid_o   read strobe to memory
//   model_data_i         memory read data
//   rdata_o / rvalid_o   returned data and its one-cycle valid
module model_read_port
  import model_table_reader_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] model_addr_o,
  output logic              model_read_valid_o,
  input  logic [DATA_W-1:0] model_data_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);

  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Down-counter loaded at the strobe; data is valid when it reaches zero
  // while a read is pending, i.e. READ_LAT cycles after the strobe.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    addr_d = addr_q;
    if (req_i) begin
      pend_d = 1'b1;
      cnt_d  = CNT_W'(READ_LAT - 1);
      addr_d = addr_i;
    end else if (pend_q) begin
      if (cnt_q == '0) begin
        pend_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      addr_q <= addr_d;
    end
  end

  assign model_read_valid_o = req_i;
  assign model_addr_o       = req_i ? addr_i : addr_q;
  assign rdata_o            = model_data_i;
  assign rvalid_o           = pend_q && (cnt_q == '0);

endmodule

// File: rtl/model_table_reader.sv
// model_table_reader
//   Walks the forward or backward compute table plus the intermediate-mem
//   table of model_config_mem, one layer at a time, and emits one
//   {layer, compute, intermediate} descriptor per layer on a valid/ready stream.
//   Forward walks layer 0..N-1, backward walks N-1..0.
// Ports
//   clk_i, rst_ni              clock / async active-low reset
//   start_i, direction_i       start request and walk direction (sampled in IDLE)
//   num_layers_i               layer count, clamped to MAX_LAYERS
//   model_addr_o, model_read_valid_o, model_data_i   memory read port
//   desc_valid_o, desc_ready_i, desc_layer_o, desc_compute_o, desc_interm_o
//                              descriptor stream
//   busy_o, done_o             walk in progress / one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start_i
// RD_C   | compute-table read strobe
// WT_C   | waiting for compute data
// RD_I   | intermediate-mem read strobe
// WT_I   | waiting for intermediate data
// EMIT   | descriptor valid, waiting for ready
// DONE   | one-cycle done pulse
module model_table_reader
  import model_table_reader_pkg::*;
#(
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned MAX_LAYERS = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               direction_i,
  input  logic [LAYER_W-1:0] num_layers_i,
  output logic [ADDR_W-1:0]  model_addr_o,
  output logic               model_read_valid_o,
  input  logic [DATA_W-1:0]  model_data_i,
  output logic               desc_valid_o,
  input  logic               desc_ready_i,
  output logic [IDX_W-1:0]   desc_layer_o,
  output logic [DATA_W-1:0]  desc_compute_o,
  output logic [DATA_W-1:0]  desc_interm_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_C = 3'd1,
    S_WT_C = 3'd2,
    S_RD_I = 3'd3,
    S_WT_I = 3'd4,
    S_EMIT = 3'd5,
    S_DONE = 3'd6
  } state_e;

  localparam logic [LAYER_W-1:0] MAX_N = LAYER_W'(MAX_LAYERS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               dir_q, dir_d;
  logic [LAYER_W-1:0] n_q, n_d;
  logic [DATA_W-1:0]  comp_q, comp_d;
  logic [DATA_W-1:0]  interm_q, interm_d;

  logic               rd_req;
  logic [2:0]         rd_sel;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_W-1:0]  rd_rdata;
  logic               rd_rvalid;
  logic [LAYER_W-1:0] n_clamped;
  logic               last_layer;

  assign n_clamped  = clamp_layers(num_layers_i, MAX_N);
  // Backward walks end at 0, so the decrement never wraps.
  assign last_layer = dir_q ? (idx_q == '0) : ({1'b0, idx_q} == (n_q - LAYER_W'(1)));
  assign rd_addr    = table_addr(rd_sel, idx_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    n_d      = n_q;
    comp_d   = comp_q;
    interm_d = interm_q;
    rd_req   = 1'b0;
    rd_sel   = SEL_INT;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dir_d = direction_i;
          n_d   = n_clamped;
          idx_d = direction_i ? IDX_W'(n_clamped - LAYER_W'(1)) : '0;
          state_d = (n_clamped == '0) ? S_DONE : S_RD_C;
        end
      end
      S_RD_C: begin
        rd_req  = 1'b1;
        rd_sel  = dir_q ? SEL_BWD : SEL_FWD;
        state_d = S_WT_C;
      end
      S_WT_C: begin
        if (rd_rvalid) begin
          comp_d  = rd_rdata;
          state_d = S_RD_I;
        end
      end
      S_RD_I: begin
        rd_req  = 1'b1;
        rd_sel  = SEL_INT;
        state_d = S_WT_I;
      end
      S_WT_I: begin
        if (rd_rvalid) begin
          interm_d = rd_rdata;
          state_d  = S_EMIT;
        end
      end
      S_EMIT: begin
        if (desc_ready_i) begin
          if (last_layer) begin
            state_d = S_DONE;
          end else begin
            idx_d   = dir_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
            state_d = S_RD_C;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      n_q      <= '0;
      comp_q   <= '0;
      interm_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      n_q      <= n_d;
      comp_q   <= comp_d;
      interm_q <= interm_d;
    end
  end

  model_read_port #(
    .READ_LAT (READ_LAT)
  ) u_read_port (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_i              (rd_req),
    .addr_i             (rd_addr),
    .model_addr_o       (model_addr_o),
    .model_read_valid_o (model_read_valid_o),
    .model_data_i       (model_data_i),
    .rdata_o            (rd_rdata),
    .rvalid_o           (rd_rvalid)
  );

  // All stream/status outputs decode registered state only, so ready never
  // reaches valid combinationally.
  assign desc_valid_o   = (state_q == S_EMIT);
  assign desc_layer_o   = idx_q;
  assign desc_compute_o = comp_q;
  assign desc_interm_o  = interm_q;
  assign done_o         = (state_q == S_DONE);
  assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_model_table_reader.sv
// Bench for model_table_reader with a behavioural READ_LAT=1 memory and a
// list-based reference of the expected walk.
`include "define.v"

module tb_model_table_reader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        direction_i = 1'b0;
  logic [5:0]  num_layers_i = '0;
  logic [31:0] model_addr_o;
  logic        model_read_valid_o;
  logic [31:0] model_data_i = 32'hDEAD_BEEF;
  logic        desc_valid_o;
  logic        desc_ready_i = 1'b1;
  logic [4:0]  desc_layer_o;
  logic [31:0] desc_compute_o;
  logic [31:0] desc_interm_o;
  logic        busy_o;
  logic        done_o;

  always #5 clk_i = ~clk_i;

  model_table_reader #(.READ_LAT(1), .MAX_LAYERS(32)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .start_i            (start_i),
    .direction_i        (direction_i),
    .num_layers_i       (num_layers_i),
    .model_addr_o       (model_addr_o),
    .model_read_valid_o (model_read_valid_o),
    .model_data_i       (model_data_i),
    .desc_valid_o       (desc_valid_o),
    .desc_ready_i       (desc_ready_i),
    .desc_layer_o       (desc_layer_o),
    .desc_compute_o     (desc_compute_o),
    .desc_interm_o      (desc_interm_o),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural memory: data valid the cycle after the strobe, garbage otherwise.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [2:0] sel;
    int idx;
    sel = a[10:8];
    idx = int'(a[4:0]);
    if (sel == `FORWARD_COMPUTE)  return 32'(100 + idx);
    if (sel == `BACKWARD_COMPUTE) return 32'(300 + idx);
    if (sel == `INTERMEDIATE_MEM) return 32'(200 + idx);
    return 32'hEEEE_EEEE;
  endfunction

  always @(posedge clk_i) begin
    if (model_read_valid_o) model_data_i <= mem_read(model_addr_o);
    else                    model_data_i <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [4:0]  layer;
    logic [31:0] comp;
    logic [31:0] interm;
    int          cyc;
  } desc_t;

  int          cyc = 0;
  logic [31:0] addr_log[$];
  desc_t       got[$];
  int          strobe_cnt, done_cnt, done_cyc, first_strobe_cyc, viol;
  bit          prev_stall;
  logic [4:0]  p_layer;
  logic [31:0] p_comp, p_interm;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (model_read_valid_o) begin
      if (strobe_cnt == 0) first_strobe_cyc = cyc;
      strobe_cnt++;
      addr_log.push_back(model_addr_o);
    end
    if (desc_valid_o && desc_ready_i)
      got.push_back('{layer: desc_layer_o, comp: desc_compute_o, interm: desc_interm_o, cyc: cyc});
    if (done_o) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
    end
    if (rst_ni) begin
      if (prev_stall && !(desc_valid_o && desc_layer_o == p_layer &&
                          desc_compute_o == p_comp && desc_interm_o == p_interm)) viol++;
      if (desc_valid_o && model_read_valid_o) viol++;
      if ((desc_valid_o || model_read_valid_o) && !busy_o) viol++;
      if (done_o && busy_o) viol++;
    end
    prev_stall = rst_ni && desc_valid_o && !desc_ready_i;
    p_layer    = desc_layer_o;
    p_comp     = desc_compute_o;
    p_interm   = desc_interm_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    got.delete();
    strobe_cnt = 0; done_cnt = 0; done_cyc = -1; first_strobe_cyc = -1; viol = 0;
  endtask

  // mode: 0 = ready high, 1 = random ready, 2 = ready low for 5 cycles on the first descriptor
  task automatic run_walk(input string name, input bit dir, input int n, input int mode,
                          input bit restart);
    int exp_n, start_cyc, held, lay;
    logic [31:0] exp_addr;
    exp_n = (n > 32) ? 32 : n;
    held  = 0;
    clear_logs();
    desc_ready_i = (mode != 2);
    @(posedge clk_i); #1;
    start_i = 1'b1; direction_i = dir; num_layers_i = 6'(n);
    start_cyc = cyc;
    @(posedge clk_i); #1;
    start_i = 1'b0; direction_i = 1'($urandom_range(0, 1)); num_layers_i = 6'($urandom_range(0, 63));
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      case (mode)
        0: desc_ready_i = 1'b1;
        1: desc_ready_i = ($urandom_range(0, 2) != 0);
        default: begin
          if (desc_valid_o && got.size() == 0 && held < 5) begin
            desc_ready_i = 1'b0; held++;
          end else desc_ready_i = 1'b1;
        end
      endcase
      if (restart && c == 6) begin
        start_i = 1'b1; direction_i = ~dir; num_layers_i = 6'd7;
      end else start_i = 1'b0;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end

    chk({name, " done_count"}, done_cnt, 1);
    chk({name, " strobes"}, strobe_cnt, 2 * exp_n);
    chk({name, " desc_count"}, got.size(), exp_n);
    chk({name, " protocol_violations"}, viol, 0);
    for (int k = 0; k < exp_n && k < got.size(); k++) begin
      lay = dir ? (exp_n - 1 - k) : k;
      chk($sformatf("%s desc%0d layer", name, k), got[k].layer, lay);
      chk($sformatf("%s desc%0d data", name, k), {got[k].comp, got[k].interm},
          {32'((dir ? 300 : 100) + lay), 32'(200 + lay)});
      if (mode == 0)
        chk($sformatf("%s desc%0d timing", name, k), got[k].cyc - first_strobe_cyc, 4 + 5 * k);
    end
    for (int k = 0; k < exp_n && 2 * k + 1 < addr_log.size(); k++) begin
      lay = dir ? (exp_n - 1 - k) : k;
      exp_addr = ((dir ? 32'(`BACKWARD_COMPUTE) : 32'(`FORWARD_COMPUTE)) << 8) | 32'(lay);
      chk($sformatf("%s addr_c%0d", name, k), addr_log[2 * k], exp_addr);
      exp_addr = (32'(`INTERMEDIATE_MEM) << 8) | 32'(lay);
      chk($sformatf("%s addr_i%0d", name, k), addr_log[2 * k + 1], exp_addr);
    end
    if (exp_n == 0)
      chk({name, " done_after_start"}, done_cyc, start_cyc + 1);
    else if (got.size() > 0)
      chk({name, " done_after_last"}, done_cyc, got[got.size() - 1].cyc + 1);
    if (mode == 2 && got.size() >= 2) begin
      chk({name, " stall_len"}, got[0].cyc - first_strobe_cyc, 9);
      chk({name, " second_after_hs"}, got[1].cyc - got[0].cyc, 5);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_logs();
    prev_stall = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset ctrl", {model_addr_o, model_read_valid_o, desc_valid_o, desc_layer_o, busy_o, done_o}, 64'd0);
    chk("reset data", {desc_compute_o, desc_interm_o}, 64'd0);
    rst_ni = 1'b1;

    run_walk("fwd4", 1'b0, 4, 0, 1'b0);
    run_walk("bwd3", 1'b1, 3, 0, 1'b0);
    run_walk("fwd2_stall", 1'b0, 2, 2, 1'b0);
    run_walk("empty", 1'b0, 0, 0, 1'b0);
    run_walk("fwd40", 1'b0, 40, 0, 1'b0);
    run_walk("restart_ign", 1'b1, 5, 0, 1'b1);

    // Reset while waiting for intermediate data of layer 0.
    clear_logs();
    @(posedge clk_i); #1;
    start_i = 1'b1; direction_i = 1'b0; num_layers_i = 6'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int c = 0; c < 50 && strobe_cnt < 2; c++) begin @(posedge clk_i); #1; end
    chk("rst_mid reached_wt_i", strobe_cnt, 2);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid ctrl", {model_addr_o, model_read_valid_o, desc_valid_o, desc_layer_o, busy_o, done_o}, 64'd0);
    chk("rst_mid data", {desc_compute_o, desc_interm_o}, 64'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (3) begin @(posedge clk_i); #1; end
    chk("rst_mid no_done", done_cnt, 0);

    run_walk("after_rst", 1'b0, 3, 0, 1'b0);
    run_walk("bwd6_rand", 1'b1, 6, 1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      run_walk($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), $urandom_range(0, 40),
               $urandom_range(0, 1), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
